// File: rtl/vend_dispense.sv
// Vending credit dispatcher: counts owed products/nickels and runs the four-phase dispense handshakes.
// Optional ack watchdog with FAULT state enabled by defining VEND_ACK_TIMEOUT_EN.
module vend_dispense (
  input  logic       clk,
  input  logic       reset,
  input  logic       dollar,
  input  logic       nickel,
  input  logic       motor_ack,
  input  logic       change_ack,
  output logic       vend_req,
  output logic       nickel_req,
  output logic [2:0] pend_vends,
  output logic [2:0] pend_nickels,
  output logic       busy,
  output logic       overflow,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VEND      = 3'd1,
    VEND_WAIT = 3'd2,
    CHG       = 3'd3,
`ifdef VEND_ACK_TIMEOUT_EN
    CHG_WAIT  = 3'd4,
    FAULT     = 3'd5
`else
    CHG_WAIT  = 3'd4
`endif
  } state_t;

  state_t state, state_nx;
  logic   vend_inc, vend_dec;
  logic   chg_inc, chg_dec;

  assign vend_inc = dollar;
  assign chg_inc  = dollar & nickel;

`ifdef VEND_ACK_TIMEOUT_EN
  logic [3:0] wd;
  logic       wd_expired;

  assign wd_expired = (wd == 4'd14);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    vend_dec = 1'b0;
    chg_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_vends != 3'd0) begin
          state_nx = VEND;
        end else if (pend_nickels != 3'd0) begin
          state_nx = CHG;
        end
      end
      VEND: begin
        if (motor_ack) begin
          state_nx = VEND_WAIT;
          vend_dec = 1'b1;
`ifdef VEND_ACK_TIMEOUT_EN
        end else if (wd_expired) begin
          state_nx = FAULT;
`endif
        end
      end
      VEND_WAIT: begin
        if (!motor_ack) begin
          state_nx = IDLE;
        end
      end
      CHG: begin
        if (change_ack) begin
          state_nx = CHG_WAIT;
          chg_dec  = 1'b1;
`ifdef VEND_ACK_TIMEOUT_EN
        end else if (wd_expired) begin
          state_nx = FAULT;
`endif
        end
      end
      CHG_WAIT: begin
        if (!change_ack) begin
          state_nx = IDLE;
        end
      end
`ifdef VEND_ACK_TIMEOUT_EN
      FAULT: begin
        state_nx = FAULT;
      end
`endif
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // A simultaneous credit and acceptance cancel, so saturation only bites on a net increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_vends <= 3'd0;
    end else if (vend_inc && !vend_dec) begin
      if (pend_vends != 3'd7) begin
        pend_vends <= pend_vends + 3'd1;
      end
    end else if (vend_dec && !vend_inc) begin
      pend_vends <= pend_vends - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_nickels <= 3'd0;
    end else if (chg_inc && !chg_dec) begin
      if (pend_nickels != 3'd7) begin
        pend_nickels <= pend_nickels + 3'd1;
      end
    end else if (chg_dec && !chg_inc) begin
      pend_nickels <= pend_nickels - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if ((vend_inc && !vend_dec && pend_vends == 3'd7) ||
                 (chg_inc && !chg_dec && pend_nickels == 3'd7)) begin
      overflow <= 1'b1;
    end
  end

`ifdef VEND_ACK_TIMEOUT_EN
  // Cleared on the entering edge, so the request stays up 15 cycles before FAULT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd <= 4'd0;
    end else if ((state_nx == VEND || state_nx == CHG) && state_nx != state) begin
      wd <= 4'd0;
    end else if (state == VEND || state == CHG) begin
      wd <= wd + 4'd1;
    end
  end

  assign fault = (state == FAULT);
`else
  assign fault = 1'b0;
`endif

  assign vend_req   = (state == VEND);
  assign nickel_req = (state == CHG);
  assign busy       = (state != IDLE) || (pend_vends != 3'd0) || (pend_nickels != 3'd0);

endmodule

// File: tb/tb_vend_dispense.sv
// Bench for vend_dispense: owed-credit queues as reference model, negedge monitor,
// directed handshake scenarios followed by randomized strobes with a random ack responder.
module tb_vend_dispense;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dollar = 1'b0;
  logic       nickel = 1'b0;
  logic       motor_ack = 1'b0;
  logic       change_ack = 1'b0;
  logic       vend_req, nickel_req, busy, overflow, fault;
  logic [2:0] pend_vends, pend_nickels;

  int vectors = 0;
  int miscompares = 0;
  bit auto_ack = 1'b0;
  int vq[$];
  int nq[$];
  int serial = 0;
  bit movf = 1'b0;
  bit dv, dn;
  int vd = 0;
  int cd = 0;
  int tok;

  always #5 clk = ~clk;

  vend_dispense dut (
    .clk         (clk),
    .reset       (reset),
    .dollar      (dollar),
    .nickel      (nickel),
    .motor_ack   (motor_ack),
    .change_ack  (change_ack),
    .vend_req    (vend_req),
    .nickel_req  (nickel_req),
    .pend_vends  (pend_vends),
    .pend_nickels(pend_nickels),
    .busy        (busy),
    .overflow    (overflow),
    .fault       (fault)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int which, input string name);
    int n = 0;
    while (!(which != 0 ? nickel_req : vend_req) && n < 40) begin
      tick();
      n++;
    end
    chk(name, int'(which != 0 ? nickel_req : vend_req), 1);
  endtask

  task automatic hs(input int which, input string name);
    wait_req(which, name);
    if (which != 0) change_ack = 1'b1;
    else motor_ack = 1'b1;
    tick();
    if (which != 0) change_ack = 1'b0;
    else motor_ack = 1'b0;
    tick();
  endtask

  // Model: one queue entry per owed item; an accepted handshake consumes one entry.
  always @(negedge clk) begin
    if (!reset) begin
      vq.delete();
      nq.delete();
      movf = 1'b0;
    end
    chk("pend_vends", int'(pend_vends), vq.size());
    chk("pend_nickels", int'(pend_nickels), nq.size());
    chk("overflow", int'(overflow), int'(movf));
    chk("req_excl", int'(vend_req & nickel_req), 0);
`ifndef VEND_ACK_TIMEOUT_EN
    chk("fault", int'(fault), 0);
`endif
    if (vq.size() != 0 || nq.size() != 0 || vend_req || nickel_req)
      chk("busy", int'(busy), 1);
    if (!reset)
      chk("rst_req", int'(vend_req | nickel_req | busy), 0);
    if (reset) begin
      dv = vend_req && motor_ack;
      dn = nickel_req && change_ack;
      if (dv) begin
        chk("vend_owed", int'(vq.size() > 0), 1);
        if (vq.size() > 0) tok = vq.pop_front();
      end
      if (dn) begin
        chk("nickel_owed", int'(nq.size() > 0), 1);
        if (nq.size() > 0) tok = nq.pop_front();
      end
      if (dollar) begin
        if (vq.size() < 7) vq.push_back(serial++);
        else movf = 1'b1;
      end
      if (dollar && nickel) begin
        if (nq.size() < 7) nq.push_back(serial++);
        else movf = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack) begin
        if (vend_req && !motor_ack) begin
          if (vd == 0) begin
            motor_ack = 1'b1;
            vd = $urandom_range(0, 4);
          end else vd--;
        end else if (!vend_req && motor_ack && $urandom_range(0, 1) == 0) begin
          motor_ack = 1'b0;
        end
        if (nickel_req && !change_ack) begin
          if (cd == 0) begin
            change_ack = 1'b1;
            cd = $urandom_range(0, 4);
          end else cd--;
        end else if (!nickel_req && change_ack && $urandom_range(0, 1) == 0) begin
          change_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_vend_req", int'(vend_req), 0);
    chk("rst_pend", int'(pend_vends), 0);

    // single vend, ack two cycles after request
    dollar = 1'b1;
    tick();
    dollar = 1'b0;
    chk("d1_pend1", int'(pend_vends), 1);
    chk("d1_req_e0", int'(vend_req), 0);
    tick();
    chk("d1_req_e1", int'(vend_req), 1);
    tick();
    chk("d1_req_e2", int'(vend_req), 1);
    motor_ack = 1'b1;
    tick();
    chk("d1_req_e3", int'(vend_req), 0);
    chk("d1_pend0", int'(pend_vends), 0);
    motor_ack = 1'b0;
    tick();
    tick();
    chk("d1_busy", int'(busy), 0);

    // dollar + nickel: vend first, then change
    dollar = 1'b1;
    nickel = 1'b1;
    tick();
    dollar = 1'b0;
    nickel = 1'b0;
    chk("d2_pv", int'(pend_vends), 1);
    chk("d2_pn", int'(pend_nickels), 1);
    hs(0, "d2_vend");
    wait_req(1, "d2_nreq");
    chk("d2_pn_before", int'(pend_nickels), 1);
    chk("d2_vend_low", int'(vend_req), 0);
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    chk("d2_pn_after", int'(pend_nickels), 0);
    tick();
    tick();
    chk("d2_busy", int'(busy), 0);

    // nickel without dollar is ignored
    nickel = 1'b1;
    tick();
    nickel = 1'b0;
    chk("d2_lone_nickel", int'(pend_nickels), 0);

    // saturation with acks held low
    for (int i = 0; i < 8; i++) begin
      dollar = 1'b1;
      tick();
      if (i == 6) chk("d3_ovf_at7", int'(overflow), 0);
    end
    dollar = 1'b0;
    chk("d3_pend7", int'(pend_vends), 7);
    chk("d3_ovf", int'(overflow), 1);
    for (int i = 0; i < 5; i++) hs(0, "d3_drain");

    // credit and acceptance on the same edge
    wait_req(0, "d4_req");
    chk("d4_pend2", int'(pend_vends), 2);
    motor_ack = 1'b1;
    dollar = 1'b1;
    tick();
    dollar = 1'b0;
    motor_ack = 1'b0;
    chk("d4_pend_same", int'(pend_vends), 2);
    tick();
    hs(0, "d4_drain");
    hs(0, "d4_drain");
    tick();
    tick();
    chk("d4_busy", int'(busy), 0);

    // reset mid-handshake
    dollar = 1'b1;
    nickel = 1'b1;
    repeat (3) tick();
    dollar = 1'b0;
    nickel = 1'b0;
    chk("d5_pn3", int'(pend_nickels), 3);
    chk("d5_vreq", int'(vend_req), 1);
    reset = 1'b0;
    #1;
    chk("d5_vreq0", int'(vend_req), 0);
    chk("d5_nreq0", int'(nickel_req), 0);
    chk("d5_pv0", int'(pend_vends), 0);
    chk("d5_pn0", int'(pend_nickels), 0);
    chk("d5_ovf0", int'(overflow), 0);
    chk("d5_busy0", int'(busy), 0);
    chk("d5_fault0", int'(fault), 0);
    dollar = 1'b1;
    tick();
    dollar = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("d5_no_req", int'(vend_req | nickel_req), 0);
    end

    // randomized traffic
    auto_ack = 1'b1;
    repeat (800) begin
      dollar = ($urandom_range(0, 5) == 0);
      nickel = $urandom_range(0, 1) != 0;
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end
    dollar = 1'b0;
    nickel = 1'b0;
    reset = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("drain_busy", int'(busy), 0);
    chk("drain_vq", vq.size(), 0);
    chk("drain_nq", nq.size(), 0);

`ifdef VEND_ACK_TIMEOUT_EN
    auto_ack = 1'b0;
    tick();
    motor_ack = 1'b0;
    change_ack = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    dollar = 1'b1;
    tick();
    dollar = 1'b0;
    tick();
    n = 0;
    while (vend_req && n < 40) begin
      n++;
      tick();
    end
    chk("wd_cycles", n, 15);
    chk("wd_fault", int'(fault), 1);
    chk("wd_vreq", int'(vend_req), 0);
    chk("wd_pend", int'(pend_vends), 1);
    dollar = 1'b1;
    tick();
    dollar = 1'b0;
    chk("wd_strobe", int'(pend_vends), 2);
    tick();
    chk("wd_sticky", int'(fault), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vend_dispense.md
VEND_DISPENSE -- requirements
Module: vend_dispense

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port dollar, input, 1 bit: one-cycle strobe from the coin counter; one product is owed.
REQ-004 SHALL have port nickel, input, 1 bit: one-cycle strobe, qualified by dollar; one 5-cent change coin is owed.
REQ-005 SHALL have port motor_ack, input, 1 bit: product dispenser acknowledge, four-phase.
REQ-006 SHALL have port change_ack, input, 1 bit: nickel hopper acknowledge, four-phase.
REQ-007 SHALL have port vend_req, output, 1 bit: product dispense request.
REQ-008 SHALL have port nickel_req, output, 1 bit: nickel return request.
REQ-009 SHALL have port pend_vends, output, 3 bits: owed products not yet accepted.
REQ-010 SHALL have port pend_nickels, output, 3 bits: owed nickels not yet accepted.
REQ-011 SHALL have port busy, output, 1 bit: FSM not in IDLE, or either pending count nonzero.
REQ-012 SHALL have port overflow, output, 1 bit: sticky; a credit was lost to saturation.
REQ-013 SHALL have port fault, output, 1 bit: sticky acknowledge-timeout indication.

Function
REQ-014 SHALL sample dollar=1 at edge E0 and show pend_vends+1 after E0.
REQ-015 SHALL, when dollar=1 and nickel=1 at the same edge, also increment pend_nickels.
REQ-016 SHALL ignore nickel=1 while dollar=0; no count changes.
REQ-017 SHALL have a Moore FSM with states IDLE, VEND, VEND_WAIT, CHG, CHG_WAIT and FAULT.
REQ-018 SHALL drive vend_req=1 only in VEND and nickel_req=1 only in CHG.
REQ-019 SHALL, in IDLE, move to VEND if pend_vends!=0, else to CHG if pend_nickels!=0, else stay in IDLE; vends have priority.
REQ-020 SHALL, in VEND with motor_ack=1, move to VEND_WAIT and decrement pend_vends at that same edge.
REQ-021 SHALL, in VEND_WAIT, return to IDLE only once motor_ack=0.
REQ-022 SHALL apply REQ-020 and REQ-021 to CHG and CHG_WAIT, using change_ack and pend_nickels.
REQ-023 SHALL treat an ack already high on entry to VEND or CHG as accepted, so the request lasts one cycle.
REQ-024 SHALL, for a dollar strobe at E0 with FSM idle, raise vend_req after E1; minimum latency is 1 cycle.
REQ-025 SHALL, when increment and decrement of the same counter fall on one edge, leave that counter unchanged.
REQ-026 SHALL saturate both counters at 7; an increment at 7 without a simultaneous decrement sets overflow=1 and leaves the count at 7.
REQ-027 SHALL ignore acks outside VEND and CHG apart from the wait-state release checks.
REQ-028 SHALL compute busy combinationally from the registered state and counts.

Reset
REQ-029 SHALL, on reset=0 at any time (including mid-handshake), immediately force: FSM=IDLE, vend_req=0, nickel_req=0, pend_vends=0, pend_nickels=0, overflow=0, fault=0.
REQ-030 SHALL discard owed credits on reset; no request resumes after reset release.
REQ-031 SHALL ignore strobes sampled while reset=0.

Configuration
REQ-032 SHALL, with macro VEND_ACK_TIMEOUT_EN defined, add a 4-bit watchdog that clears on entry to VEND or CHG and counts each cycle in those states.
REQ-033 SHALL, with the macro defined, move to FAULT and set fault=1 when the watchdog reaches 15 without an ack.
REQ-034 SHALL, with the macro defined, hold FAULT with both requests low, leave counts unchanged, keep accepting strobes, and exit only via reset.
REQ-035 SHALL, without the macro, have no watchdog, no FAULT state, and fault tied to 0.

Verification
REQ-036 SHALL cover: reset release, dollar strobe, motor_ack returned 2 cycles after vend_req -> vend_req high 2 cycles, pend_vends 1->0, busy=0 afterwards.
REQ-037 SHALL cover: dollar+nickel in one cycle -> one vend handshake, then one nickel_req handshake; pend_nickels 1->0.
REQ-038 SHALL cover: 8 dollar strobes with motor_ack held 0 -> pend_vends=7, overflow=1 after the 8th.
REQ-039 SHALL cover: dollar strobe on the same edge that motor_ack is accepted with pend_vends=2 -> pend_vends stays 2.
REQ-040 SHALL cover: reset pulsed low while vend_req=1 and pend_nickels=3 -> all outputs 0 immediately, no request after release.
REQ-041 SHALL cover, with VEND_ACK_TIMEOUT_EN defined: vend_req with no ack -> fault=1 after 15 cycles, vend_req=0, pend_vends unchanged.
